// File: rtl/processor_pkg.sv
// processor_pkg: shared widths, opcodes, instruction field positions and FSM states for processor_core.
package processor_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int RA_W     = 3;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam int OP_LSB   = 12;
    localparam int MODE_BIT = 11;
    localparam int DR_LSB   = 8;
    localparam int SR1_LSB  = 5;
    localparam int SR2_LSB  = 2;
    localparam int BR_R_LSB = 9;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_LD_WB, S_HALTED} state_t;
endpackage

// File: rtl/processor_regfile.sv
// processor_regfile: 8x16 register file, two combinational read ports, one synchronous write port.
module processor_regfile
    import processor_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [RA_W-1:0]   ra_addr,
    input  logic [RA_W-1:0]   rb_addr,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wa] = wd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
endmodule

// File: rtl/processor_core.sv
// processor_core: 16-bit multi-cycle load/store CPU on a single-port synchronous memory.
// Define PROCESSOR_HALT_EN to make opcode 1111 a HALT; otherwise it executes as a NOP.
module processor_core
    import processor_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] currPc,
    input  logic [DATA_W-1:0] memDataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic [ADDR_W-1:0] memAddr,
    output logic              readMem,
    output logic              writeMem,
    output logic [ADDR_W-1:0] nextPc
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d, addr_sel;
    logic [3:0]        op;
    logic [RA_W-1:0]   rb_addr;
    logic [DATA_W-1:0] ra_data, rb_data, op2, alu, wd;
    logic              rd, wr, we, is_alu, is_halt, taken;

    assign op      = ir_q[OP_LSB +: 4];
    assign is_alu  = op == OP_ADD || op == OP_SUB || op == OP_AND;
    assign rb_addr = op == OP_ST  ? ir_q[DR_LSB +: RA_W] :
                     op == OP_BRZ ? ir_q[BR_R_LSB +: RA_W] : ir_q[SR2_LSB +: RA_W];
    assign op2     = ir_q[MODE_BIT] ? rb_data : {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign alu     = op == OP_ADD ? ra_data + op2 : op == OP_SUB ? ra_data - op2 : ra_data & op2;
    assign wd      = state_q == S_LD_WB ? memDataIn : alu;
    assign taken   = op == OP_BRZ && rb_data == '0;
`ifdef PROCESSOR_HALT_EN
    assign is_halt = op == OP_HALT;
`else
    assign is_halt = 1'b0;
`endif

    processor_regfile u_rf (
        .clock   (clock),
        .reset   (reset),
        .ra_addr (ir_q[SR1_LSB +: RA_W]),
        .rb_addr (rb_addr),
        .we      (we),
        .wa      (ir_q[DR_LSB +: RA_W]),
        .wd      (wd),
        .ra_data (ra_data),
        .rb_data (rb_data)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        rd      = 1'b0;
        wr      = 1'b0;
        we      = 1'b0;
        case (state_q)
            S_FETCH: begin
                rd      = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = memDataIn;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rd      = op == OP_LD && !is_halt;
                wr      = op == OP_ST;
                we      = is_alu;
                pc_d    = (op == OP_LD || is_halt) ? pc_q : taken ? currPc + ir_q[7:0] : currPc + 8'd1;
                state_d = is_halt ? S_HALTED : op == OP_LD ? S_LD_WB : S_FETCH;
            end
            S_LD_WB: begin
                we      = 1'b1;
                pc_d    = currPc + 8'd1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    // Reset idles in FETCH, so strobes are masked while reset is held.
    assign readMem    = reset & rd;
    assign writeMem   = reset & wr;
    assign addr_sel   = state_q == S_FETCH ? currPc : ir_q[7:0];
    assign memAddr    = (readMem || writeMem) ? addr_sel : mem_addr_q;
    assign mem_addr_d = memAddr;
    assign dataOut    = writeMem ? rb_data : '0;
    assign nextPc     = pc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            pc_q       <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: directed program run against a behavioural synchronous memory.
module tb_processor_core;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  currPc, memAddr, nextPc;
    logic [15:0] memDataIn = '0;
    logic [15:0] dataOut;
    logic        readMem, writeMem;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;
    assign currPc = nextPc;

    processor_core dut (
        .clock     (clock),
        .reset     (reset),
        .currPc    (currPc),
        .memDataIn (memDataIn),
        .dataOut   (dataOut),
        .memAddr   (memAddr),
        .readMem   (readMem),
        .writeMem  (writeMem),
        .nextPc    (nextPc)
    );

    function automatic logic [15:0] prog(input logic [7:0] a);
        case (a)
            8'h00: return 16'h4000;
            8'h01: return 16'h4120;
            8'h02: return 16'h4240;
            8'h03: return 16'h4360;
            8'h04: return 16'h4480;
            8'h05: return 16'h45A0;
            8'h06: return 16'h46C0;
            8'h07: return 16'h1123;
            8'h08: return 16'h1242;
            8'h09: return 16'h1B28;
            8'h0A: return 16'h730A;
            8'h0B: return 16'h640A;
            8'h0D: return 16'h2D6C;
            8'h0E: return 16'hEA02;
            8'h0F: return 16'h1483;
            8'h10: return 16'h16C1;
            8'h11: return 16'h15A1;
            8'h12: return 16'hE00E;
            8'h20: return 16'hEA02;
            8'h21: return 16'hE1DE;
            default: return 16'h0000;
        endcase
    endfunction

    // One stored word is enough: the program writes a single location.
    always @(posedge clock) begin
        if (readMem) memDataIn <= (wr_count > 0 && wr_addr == memAddr) ? wr_data : prog(memAddr);
        if (writeMem) begin
            wr_count <= wr_count + 1;
            wr_addr  <= memAddr;
            wr_data  <= dataOut;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_pc(input logic [7:0] t, output int cyc);
        cyc = 0;
        while (nextPc !== t && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clock);
        chk("rst_pc", nextPc, 16'h0);
        chk("rst_rd", readMem, 16'h0);
        chk("rst_wr", writeMem, 16'h0);
        chk("rst_addr", memAddr, 16'h0);
        chk("rst_dout", dataOut, 16'h0);
        chk("rst_r1", dut.u_rf.regs_q[1], 16'h0);
        reset = 1'b1;
        #1;
        chk("fetch_rd", readMem, 16'h1);
        chk("fetch_addr", memAddr, 16'h0);
        for (int i = 1; i <= 9; i++) begin
            wait_pc(i[7:0], c);
            chk($sformatf("lat_%0d", i), 16'(c), 16'd3);
        end
        chk("r0", dut.u_rf.regs_q[0], 16'd0);
        chk("r1", dut.u_rf.regs_q[1], 16'd3);
        chk("r2", dut.u_rf.regs_q[2], 16'd2);
        chk("r3_clr", dut.u_rf.regs_q[3], 16'd0);
        chk("r4_clr", dut.u_rf.regs_q[4], 16'd0);
        chk("r5_clr", dut.u_rf.regs_q[5], 16'd0);
        chk("r6_clr", dut.u_rf.regs_q[6], 16'd0);
        wait_pc(8'h0A, c);
        chk("lat_addr", 16'(c), 16'd3);
        chk("r3_add", dut.u_rf.regs_q[3], 16'd5);
        wait_pc(8'h0B, c);
        chk("lat_st", 16'(c), 16'd3);
        chk("st_count", 16'(wr_count), 16'd1);
        chk("st_addr", wr_addr, 16'h0A);
        chk("st_data", wr_data, 16'd5);
        wait_pc(8'h0C, c);
        chk("lat_ld", 16'(c), 16'd4);
        chk("r4_ld", dut.u_rf.regs_q[4], 16'd5);
        wait_pc(8'h0E, c);
        chk("reach_0e", nextPc, 16'h0E);
        chk("r5_sub", dut.u_rf.regs_q[5], 16'd0);
        wait_pc(8'h10, c);
        chk("lat_brz_taken", 16'(c), 16'd3);
        chk("r4_skip", dut.u_rf.regs_q[4], 16'd5);
        wait_pc(8'h11, c);
        chk("r6_add", dut.u_rf.regs_q[6], 16'd1);
        wait_pc(8'h12, c);
        chk("r5_inc", dut.u_rf.regs_q[5], 16'd1);
        wait_pc(8'h20, c);
        chk("lat_jump20", 16'(c), 16'd3);
        wait_pc(8'h21, c);
        chk("lat_untaken", 16'(c), 16'd3);
        wait_pc(8'hFF, c);
        chk("lat_back_ff", 16'(c), 16'd3);
        wait_pc(8'h00, c);
        chk("lat_wrap", 16'(c), 16'd3);
        chk("st_once", 16'(wr_count), 16'd1);
        wait_pc(8'h0B, c);
        chk("reach_0b", nextPc, 16'h0B);
        repeat (2) @(negedge clock);
        chk("ld_rd", readMem, 16'h1);
        chk("ld_addr", memAddr, 16'h0A);
        @(negedge clock);
        chk("wb_rd", readMem, 16'h0);
        chk("wb_wr", writeMem, 16'h0);
        chk("wb_addr_hold", memAddr, 16'h0A);
        reset = 1'b0;
        #1;
        chk("ar_pc", nextPc, 16'h0);
        chk("ar_rd", readMem, 16'h0);
        chk("ar_addr", memAddr, 16'h0);
        chk("ar_r4", dut.u_rf.regs_q[4], 16'd0);
        repeat (2) @(negedge clock);
        chk("ar_r4_hold", dut.u_rf.regs_q[4], 16'd0);
        reset = 1'b1;
        #1;
        chk("restart_rd", readMem, 16'h1);
        chk("restart_addr", memAddr, 16'h0);
        wait_pc(8'h01, c);
        chk("restart_lat", 16'(c), 16'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/processor_core.md
Name: processor_core

Overview:
- 16-bit, 8-register, multi-cycle load/store CPU core with an 8-bit word address space.
- Fetches instructions and data through a single-port synchronous memory: read data is registered and valid the cycle after the read is asserted.
- The PC register is exposed as nextPc. The system wires nextPc back into currPc.
- Top-level compute block; the test memory (test_memory) sits outside it.

Parameters:
- DATA_W, 16, register/instruction/data width
- ADDR_W, 8, PC and memory address width
- NUM_REGS, 8, general registers R0..R7

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- currPc  in  8  current PC, fed back from nextPc; used as fetch address and branch base
- memDataIn  in  16  memory read data, valid the cycle after readMem
- dataOut  out  16  store data, valid while writeMem=1
- memAddr  out  8  memory address for fetch/load/store
- readMem  out  1  memory read strobe
- writeMem  out  1  memory write strobe, one cycle per store
- nextPc  out  8  PC register

Behaviour:
- Reset (reset=0, async):
  - State=FETCH; nextPc=0; IR=0; R0..R7=0.
  - dataOut=0, memAddr=0, readMem=0, writeMem=0.
- Encoding: op[15:12].
  - ALU forms: [11] mode, DR[10:8], SR1[7:5]. Mode 0: imm5=[4:0], sign-extended. Mode 1: SR2=[4:2].
  - LD/ST: R[10:8], absolute address [7:0]; [11] ignored.
  - BRZ: R[11:9], signed offset9=[8:0].
- Opcodes:
  - 0001 ADD: DR=SR1+op2.
  - 0010 SUB: DR=SR1-op2.
  - 0100 AND: DR=SR1&op2.
  - 0110 LD: R=mem[addr].
  - 0111 ST: mem[addr]=R.
  - 1110 BRZ: if R==0 then PC=currPc+sext(offset9), else PC=currPc+1.
  - All other opcodes (incl. 0000): NOP.
- Arithmetic: mod 2^16, no flags. PC arithmetic mod 256: 0xFF+1 wraps to 0x00; branch targets truncate to 8 bits.
- FSM states: FETCH, DECODE, EXEC, LD_WB.
  - FETCH: readMem=1, memAddr=currPc.
  - DECODE: IR<=memDataIn at end of cycle.
  - EXEC:
    - ALU: write DR, nextPc<=currPc+1, go to FETCH.
    - BRZ/NOP: update nextPc, go to FETCH.
    - ST: writeMem=1, memAddr=addr, dataOut=R; nextPc+1; go to FETCH.
    - LD: readMem=1, memAddr=addr; go to LD_WB.
  - LD_WB: R<=memDataIn, nextPc<=currPc+1, go to FETCH.
- Latency: ALU/BRZ/ST/NOP 3 cycles; LD 4 cycles.
- Strobe rules:
  - readMem and writeMem are never both high.
  - Both are low in DECODE and LD_WB.
  - memAddr holds its last value when no strobe is asserted.
- Register reads see writes completed in earlier instructions. Register file writes occur only at the end of EXEC or LD_WB.
- Reset mid-instruction aborts the instruction; no register write occurs; execution restarts at PC 0.

Optional Feature:
- PROCESSOR_HALT_EN
  - Defined: opcode 1111 = HALT. EXEC enters HALTED state: no strobes, nextPc frozen. Only reset exits HALTED.
  - Undefined: 1111 is a NOP.

Decomposition:
- Package processor_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_LD, OP_ST, OP_BRZ, OP_HALT
  - state enum state_t
  - field bit-position constants
- Sub-module processor_regfile: 8x16, two combinational read ports (SR1, SR2/R), one synchronous write port, async active-low clear.

Test Plan:
- Clear and immediate add: program 0x4000 0x4120 0x4240 0x4360 0x4480 0x45A0 0x46C0, then 0x1123 and 0x1242.
  -> R0..R6=0, R1=3, R2=2; each instruction takes 3 cycles.
- ADD register form: R3=R1+R2 (mode 1).
  -> R3=5.
- ST R3 to 0x0A, then LD R4 from 0x0A.
  -> writeMem pulses one cycle with memAddr=0x0A, dataOut=5; R4=5; LD takes 4 cycles.
- SUB then taken branch: 0x2D6C at 0x0D, then 0xEA02 at 0x0E.
  -> R5=0; branch jumps to 0x10, skipping 0x0F (0x1483); 0x10 (0x16C1) gives R6=1; R4 stays 5.
- Untaken branch with R5=1, offset 2 at PC 0x20.
  -> nextPc=0x21.
- Async reset asserted during LD_WB.
  -> immediate clear: nextPc=0, strobes low, destination register unchanged from its reset value 0; fetch restarts at 0x00 after release.
